cpu_run_ctrl: RTL

Run controller for the 8-bit accumulator computer. It loads a program into instruction memory through a valid/ready write channel and holds the CPU in reset for one cycle at start. It then runs the CPU until the PC hits a programmable breakpoint or a cycle budget expires, and freezes it with a snapshot of regA, regB and the ALU output. It sits beside the computer, gates its clock enable, and replaces ad-hoc memory patching and PC polling with a synthesizable, parametrised harness.

---
 rtl/cpu_ctrl_pkg.sv | 25 ++
 rtl/sat_counter.sv | 26 ++
 rtl/cpu_run_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller: default widths, FSM states
// and run status codes.
package cpu_ctrl_pkg;

  localparam int unsigned DEF_INSTR_W      = 9;
  localparam int unsigned DEF_PC_W         = 4;
  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_DRAIN_CYCLES = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_BREAK   = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: i_clk, i_rst (sync, active-high), i_clr (sync clear), i_en (count),
//        o_count (current value, holds at all-ones).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the 8-bit accumulator computer: loads instruction memory
// over a valid/ready channel, resets the CPU for one cycle on start, runs it
// until a breakpoint or cycle budget, then freezes it and snapshots its taps.
// Ports:
//   i_clk, i_rst                       clock, sync active-high reset
//   i_ld_valid/o_ld_ready, i_ld_addr,
//   i_ld_data                          program-load handshake
//   i_start                            one-cycle run request
//   i_bp_en, i_bp_addr, i_max_cycles   breakpoint and budget (0 = unlimited)
//   o_im_we, o_im_waddr, o_im_wdata    instruction-memory write port
//   o_cpu_en, o_cpu_rst                CPU clock enable and reset
//   i_pc, i_reg_a, i_reg_b, i_alu_out  CPU observation taps
//   o_done, o_status, o_cycles         run result
//   o_snap_a, o_snap_b, o_snap_alu     taps captured on entering DONE
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W      = DEF_INSTR_W,
  parameter int unsigned PC_W         = DEF_PC_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ld_valid,
  output logic               o_ld_ready,
  input  logic [PC_W-1:0]    i_ld_addr,
  input  logic [INSTR_W-1:0] i_ld_data,
  input  logic               i_start,
  input  logic               i_bp_en,
  input  logic [PC_W-1:0]    i_bp_addr,
  input  logic [CNT_W-1:0]   i_max_cycles,
  output logic               o_im_we,
  output logic [PC_W-1:0]    o_im_waddr,
  output logic [INSTR_W-1:0] o_im_wdata,
  output logic               o_cpu_en,
  output logic               o_cpu_rst,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [DATA_W-1:0]  i_reg_a,
  input  logic [DATA_W-1:0]  i_reg_b,
  input  logic [DATA_W-1:0]  i_alu_out,
  output logic               o_done,
  output logic [1:0]         o_status,
  output logic [CNT_W-1:0]   o_cycles,
  output logic [DATA_W-1:0]  o_snap_a,
  output logic [DATA_W-1:0]  o_snap_b,
  output logic [DATA_W-1:0]  o_snap_alu
);

  // Drain countdown terminal value; unused when DRAIN_CYCLES is 0.
  localparam int unsigned DRAIN_LAST = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;

  state_e               r_state;
  state_e               w_next;
  logic                 r_bp_en;
  logic [PC_W-1:0]      r_bp_addr;
  logic [CNT_W-1:0]     r_max;
  status_e              r_status;
  status_e              w_status_val;
  logic                 w_status_set;
  logic                 r_im_we;
  logic [PC_W-1:0]      r_im_waddr;
  logic [INSTR_W-1:0]   r_im_wdata;
  logic [DATA_W-1:0]    r_snap_a;
  logic [DATA_W-1:0]    r_snap_b;
  logic [DATA_W-1:0]    r_snap_alu;
  logic [CNT_W-1:0]     w_cycles;
  logic [CNT_W-1:0]     w_drain_cnt;
  logic                 w_idle_or_done;
  logic                 w_start_acc;
  logic                 w_load_acc;
  logic                 w_break;
  logic                 w_timeout;
  logic                 w_cpu_en;
  logic                 w_ld_ready;

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_acc    = i_start && w_idle_or_done;
  assign w_ld_ready     = w_idle_or_done && !i_start;
  assign w_load_acc     = i_ld_valid && w_ld_ready;
  assign w_cpu_en       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_break        = r_bp_en && (i_pc == r_bp_addr);
  // Widened compare so a saturated count can never alias a budget match.
  assign w_timeout      = (r_max != '0) &&
                          ((CNT_W+1)'(w_cycles) + (CNT_W+1)'(1) == (CNT_W+1)'(r_max));

  // Enabled-cycle count of the current/last run.
  sat_counter #(.W(CNT_W)) u_cycles (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start_acc),
    .i_en    (w_cpu_en),
    .o_count (w_cycles)
  );

  // Cycles spent in DRAIN; held at zero outside it.
  sat_counter #(.W(CNT_W)) u_drain (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (r_state != S_DRAIN),
    .i_en    (r_state == S_DRAIN),
    .o_count (w_drain_cnt)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and status decision; break outranks timeout.
  always_comb begin
    w_next       = r_state;
    w_status_set = 1'b0;
    w_status_val = ST_NONE;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_acc) w_next = S_CLEAR;
      end
      S_CLEAR: w_next = S_RUN;
      S_RUN: begin
        if (w_break) begin
          w_next       = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
          w_status_set = 1'b1;
          w_status_val = ST_BREAK;
        end else if (w_timeout) begin
          w_next       = S_DONE;
          w_status_set = 1'b1;
          w_status_val = ST_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (w_drain_cnt == CNT_W'(DRAIN_LAST)) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Run configuration, status, memory write port and snapshots.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bp_en    <= 1'b0;
      r_bp_addr  <= '0;
      r_max      <= '0;
      r_status   <= ST_NONE;
      r_im_we    <= 1'b0;
      r_im_waddr <= '0;
      r_im_wdata <= '0;
      r_snap_a   <= '0;
      r_snap_b   <= '0;
      r_snap_alu <= '0;
    end else begin
      r_im_we <= w_load_acc;
      if (w_load_acc) begin
        r_im_waddr <= i_ld_addr;
        r_im_wdata <= i_ld_data;
      end
      if (w_start_acc) begin
        r_bp_en   <= i_bp_en;
        r_bp_addr <= i_bp_addr;
        r_max     <= i_max_cycles;
        r_status  <= ST_NONE;
      end else if (w_status_set) begin
        r_status <= w_status_val;
      end
      // Taps sampled on the edge that enters DONE.
      if ((w_next == S_DONE) && (r_state != S_DONE)) begin
        r_snap_a   <= i_reg_a;
        r_snap_b   <= i_reg_b;
        r_snap_alu <= i_alu_out;
      end
    end
  end

  assign o_ld_ready = w_ld_ready;
  assign o_cpu_en   = w_cpu_en;
  assign o_cpu_rst  = (r_state == S_CLEAR);
  assign o_done     = (r_state == S_DONE);
  assign o_status   = r_status;
  assign o_cycles   = w_cycles;
  assign o_im_we    = r_im_we;
  assign o_im_waddr = r_im_waddr;
  assign o_im_wdata = r_im_wdata;
  assign o_snap_a   = r_snap_a;
  assign o_snap_b   = r_snap_b;
  assign o_snap_alu = r_snap_alu;

endmodule
